// File: rtl/pcileech_com_tx64.sv
// 64->32 serializer for the COM TX path: upper DWORD first, optional 0x66665555 resync pairs on 64-bit boundaries.
// Optional feature: define COM_TX_RESYNC_EN to enable resync-pair insertion.
module pcileech_com_tx64 #(
    parameter logic [15:0] RESYNC_INTERVAL = 16'd4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [31:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    input  logic        resync_req,
    output logic [31:0] word_count,
    output logic [15:0] sync_count
);
    typedef enum logic [2:0] {IDLE, HI, LO, SYNC1, SYNC2} state_t;
    localparam logic [31:0] SYNC_WORD = 32'h66665555;

    state_t      state_q, state_d;
    logic [63:0] hold_q, hold_d;
    logic [31:0] word_cnt_q, word_cnt_d;
    logic [15:0] sync_cnt_q, sync_cnt_d;
    logic        pending_q, pending_d;
    logic        resync_due;
    logic        in_xfer, out_xfer, enter_sync1;

    assign in_xfer     = din_valid & din_ready;
    assign out_xfer    = dout_valid & dout_ready;
    assign enter_sync1 = (state_d == SYNC1) && (state_q != SYNC1);

`ifdef COM_TX_RESYNC_EN
    localparam logic PEND_RST = 1'b1;
    logic [15:0] interval_q, interval_d;
    logic        interval_hit;

    // The LO transfer that completes the Nth word must already steer to SYNC1,
    // so the interval hit is looked ahead rather than waiting for the flag.
    assign interval_hit = (RESYNC_INTERVAL != 16'd0) && (state_q == LO) &&
                          (interval_q + 16'd1 == RESYNC_INTERVAL);
    assign resync_due   = pending_q | interval_hit;

    always_comb begin
        interval_d = interval_q;
        if (enter_sync1)
            interval_d = '0;
        else if (state_q == LO && out_xfer && interval_q != RESYNC_INTERVAL)
            interval_d = interval_q + 16'd1;
    end

    always_comb begin
        pending_d  = (pending_q & ~enter_sync1) | resync_req;
        sync_cnt_d = sync_cnt_q;
        if (state_q == SYNC2 && out_xfer)
            sync_cnt_d = sync_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) interval_q <= '0;
        else        interval_q <= interval_d;
    end
`else
    localparam logic PEND_RST = 1'b0;
    logic [16:0] unused_cfg;
    assign unused_cfg = {resync_req, RESYNC_INTERVAL};
    assign resync_due = pending_q;

    always_comb begin
        pending_d  = 1'b0;
        sync_cnt_d = '0;
    end
`endif

    // dout_ready -> din_ready is combinational so LO can hand straight over to the next HI.
    assign din_ready = ~resync_due & ((state_q == IDLE) | ((state_q == LO) & dout_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (resync_due)   state_d = SYNC1;
                else if (in_xfer) state_d = HI;
            end
            HI:    if (out_xfer) state_d = LO;
            LO: begin
                if (out_xfer) begin
                    if (resync_due)   state_d = SYNC1;
                    else if (in_xfer) state_d = HI;
                    else              state_d = IDLE;
                end
            end
            SYNC1: if (out_xfer) state_d = SYNC2;
            SYNC2: if (out_xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dout_valid = 1'b1;
        dout       = SYNC_WORD;
        case (state_q)
            HI:          dout = hold_q[63:32];
            LO:          dout = hold_q[31:0];
            SYNC1, SYNC2: dout = SYNC_WORD;
            default: begin
                dout_valid = 1'b0;
                dout       = '0;
            end
        endcase
    end

    always_comb begin
        hold_d     = in_xfer ? din : hold_q;
        word_cnt_d = word_cnt_q;
        if (state_q == LO && out_xfer)
            word_cnt_d = word_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            word_cnt_q <= '0;
            sync_cnt_q <= '0;
            pending_q  <= PEND_RST;
        end else begin
            hold_q     <= hold_d;
            word_cnt_q <= word_cnt_d;
            sync_cnt_q <= sync_cnt_d;
            pending_q  <= pending_d;
        end
    end

    assign word_count = word_cnt_q;
    assign sync_count = sync_cnt_q;
endmodule

// File: tb/tb_pcileech_com_tx64.sv
// Directed bench for pcileech_com_tx64; expectations follow COM_TX_RESYNC_EN when it is defined.
module tb_pcileech_com_tx64;
    localparam int          INTERVAL = 4;
    localparam logic [31:0] S        = 32'h66665555;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [63:0] din = '0;
    logic        din_valid = 1'b0, din_ready;
    logic [31:0] dout;
    logic        dout_valid, dout_ready = 1'b0, resync_req = 1'b0;
    logic [31:0] word_count;
    logic [15:0] sync_count;

    int errs = 0, checks = 0, cyc = 0;
    int exp_words = 0, exp_syncs = 0, since_sync = 0, stall_bad = 0;
    logic [63:0] wq[$];
    logic [31:0] got[$], exp_q[$];
    int          got_cyc[$], acc_cyc[$];

    pcileech_com_tx64 #(.RESYNC_INTERVAL(16'(INTERVAL))) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .resync_req(resync_req),
        .word_count(word_count), .sync_count(sync_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic clear_q();
        wq.delete(); got.delete(); exp_q.delete(); got_cyc.delete(); acc_cyc.delete();
    endtask

    task automatic add_sync();
        exp_q.push_back(S); exp_q.push_back(S);
        exp_syncs++; since_sync = 0;
    endtask

    task automatic add_word(input logic [63:0] w);
        wq.push_back(w);
        exp_q.push_back(w[63:32]); exp_q.push_back(w[31:0]);
        exp_words++; since_sync++;
`ifdef COM_TX_RESYNC_EN
        if (since_sync == INTERVAL) add_sync();
`endif
    endtask

    // Drives wq into the DUT and records every output transfer; entered and left at posedge+1.
    task automatic stream(input bit toggle, input int max_cyc);
        int idx = 0;
        bit inx, prev_stall = 0;
        logic [31:0] prev_dout = '0;
        stall_bad = 0;
        for (int c = 0; c < max_cyc; c++) begin
            din_valid = (idx < wq.size());
            if (din_valid) din = wq[idx]; else din = '0;
            dout_ready = toggle ? (c % 2 == 0) : 1'b1;
            @(negedge clk);
            inx = din_valid && din_ready;
            if (inx) acc_cyc.push_back(cyc);
            if (dout_valid && dout_ready) begin got.push_back(dout); got_cyc.push_back(cyc); end
            if (prev_stall && dout !== prev_dout) stall_bad++;
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            @(posedge clk); #1;
            if (inx) idx++;
            if (idx == wq.size() && got.size() >= exp_q.size()) break;
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic exp_rdy;
`ifdef COM_TX_RESYNC_EN
        exp_rdy = 1'b0;
`else
        exp_rdy = 1'b1;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (dout_valid !== 1'b0) begin errs++; $display("FAIL rst_dout_valid: got %b want 0", dout_valid); end
        checks++; if (dout !== 32'h0) begin errs++; $display("FAIL rst_dout: got %h want 0", dout); end
        checks++; if (word_count !== 32'h0) begin errs++; $display("FAIL rst_word_count: got %0d want 0", word_count); end
        checks++; if (sync_count !== 16'h0) begin errs++; $display("FAIL rst_sync_count: got %0d want 0", sync_count); end
        checks++; if (din_ready !== exp_rdy) begin errs++; $display("FAIL rst_din_ready: got %b want %b", din_ready, exp_rdy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_startup();
        clear_q();
`ifdef COM_TX_RESYNC_EN
        add_sync();
`endif
        stream(1'b0, 20);
        checks++; if (got.size() != exp_q.size()) begin errs++; $display("FAIL startup_len: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errs++; $display("FAIL startup_dw[%0d]: got %h want %h", i, got[i], exp_q[i]); end
        end
        @(negedge clk);
        checks++; if (dout_valid !== 1'b0) begin errs++; $display("FAIL startup_idle: got %b want 0", dout_valid); end
        checks++; if (sync_count !== 16'(exp_syncs)) begin errs++; $display("FAIL startup_sync_count: got %0d want %0d", sync_count, exp_syncs); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        clear_q();
        add_word(64'h11111111_22222222);
        add_word(64'h33333333_44444444);
        stream(1'b0, 40);
        checks++; if (got.size() != exp_q.size()) begin errs++; $display("FAIL b2b_len: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errs++; $display("FAIL b2b_dw[%0d]: got %h want %h", i, got[i], exp_q[i]); end
        end
        if (got_cyc.size() >= 4 && acc_cyc.size() >= 1) begin
            checks++; if (got_cyc[0] != acc_cyc[0] + 1) begin errs++; $display("FAIL b2b_latency: got cycle %0d want %0d", got_cyc[0], acc_cyc[0] + 1); end
            checks++; if (got_cyc[3] != got_cyc[0] + 3) begin errs++; $display("FAIL b2b_bubble: got span %0d want 3", got_cyc[3] - got_cyc[0]); end
        end
        checks++; if (word_count !== 32'(exp_words)) begin errs++; $display("FAIL b2b_word_count: got %0d want %0d", word_count, exp_words); end
    endtask

    task automatic test_stall();
        clear_q();
        for (int i = 0; i < 8; i++) add_word({8'hA0 + 8'(i), 24'h00_1234, 8'hB0 + 8'(i), 24'h00_5678});
        stream(1'b1, 300);
        checks++; if (got.size() != exp_q.size()) begin errs++; $display("FAIL stall_len: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errs++; $display("FAIL stall_dw[%0d]: got %h want %h", i, got[i], exp_q[i]); end
        end
        checks++; if (stall_bad != 0) begin errs++; $display("FAIL stall_stable: got %0d changes want 0", stall_bad); end
        checks++; if (word_count !== 32'(exp_words)) begin errs++; $display("FAIL stall_word_count: got %0d want %0d", word_count, exp_words); end
        checks++; if (sync_count !== 16'(exp_syncs)) begin errs++; $display("FAIL stall_sync_count: got %0d want %0d", sync_count, exp_syncs); end
    endtask

    task automatic test_interval();
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        exp_words = 0; exp_syncs = 0; since_sync = 0;
        clear_q();
`ifdef COM_TX_RESYNC_EN
        add_sync();
`endif
        for (int i = 1; i <= 10; i++) add_word({32'(i), 32'(i) ^ 32'hFFFF_0000});
        stream(1'b0, 200);
        checks++; if (got.size() != exp_q.size()) begin errs++; $display("FAIL interval_len: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errs++; $display("FAIL interval_dw[%0d]: got %h want %h", i, got[i], exp_q[i]); end
        end
        checks++; if (word_count !== 32'd10) begin errs++; $display("FAIL interval_word_count: got %0d want 10", word_count); end
        checks++; if (sync_count !== 16'(exp_syncs)) begin errs++; $display("FAIL interval_sync_count: got %0d want %0d", sync_count, exp_syncs); end
    endtask

    task automatic test_resync_req();
        logic [63:0] a = 64'hC0FFEE01_DEADBE01;
        clear_q();
        din = a; din_valid = 1'b1; dout_ready = 1'b1;
        @(negedge clk);
        checks++; if (din_ready !== 1'b1) begin errs++; $display("FAIL req_accept: got %b want 1", din_ready); end
        @(posedge clk); #1;
        din_valid = 1'b0; resync_req = 1'b1;
        @(negedge clk);
        checks++; if (dout_valid !== 1'b1 || dout !== a[63:32]) begin errs++; $display("FAIL req_hi: got %b/%h want 1/%h", dout_valid, dout, a[63:32]); end
        @(posedge clk); #1;
        resync_req = 1'b0;
        exp_q.push_back(a[31:0]); exp_words++; since_sync++;
`ifdef COM_TX_RESYNC_EN
        add_sync();
`endif
        add_word(64'h0BADF00D_12345678);
        stream(1'b0, 40);
        checks++; if (got.size() != exp_q.size()) begin errs++; $display("FAIL req_len: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errs++; $display("FAIL req_dw[%0d]: got %h want %h", i, got[i], exp_q[i]); end
        end
        checks++; if (sync_count !== 16'(exp_syncs)) begin errs++; $display("FAIL req_sync_count: got %0d want %0d", sync_count, exp_syncs); end
    endtask

    task automatic test_reset_midword();
        logic [63:0] a = 64'hAAAAAAAA_BBBBBBBB;
        clear_q();
        din = a; din_valid = 1'b1; dout_ready = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (dout_valid !== 1'b1 || dout !== a[31:0]) begin errs++; $display("FAIL mid_lo_pending: got %b/%h want 1/%h", dout_valid, dout, a[31:0]); end
        rst_n = 1'b0; #1;
        checks++; if (dout_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_valid: got %b want 0", dout_valid); end
        checks++; if (dout !== 32'h0) begin errs++; $display("FAIL mid_rst_dout: got %h want 0", dout); end
        checks++; if (word_count !== 32'h0 || sync_count !== 16'h0) begin errs++; $display("FAIL mid_rst_counts: got %0d/%0d want 0/0", word_count, sync_count); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_words = 0; exp_syncs = 0; since_sync = 0;
`ifdef COM_TX_RESYNC_EN
        add_sync();
`endif
        add_word(64'h5A5A5A5A_A5A5A5A5);
        stream(1'b0, 40);
        checks++; if (got.size() != exp_q.size()) begin errs++; $display("FAIL mid_len: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errs++; $display("FAIL mid_dw[%0d]: got %h want %h", i, got[i], exp_q[i]); end
        end
        checks++; if (word_count !== 32'd1) begin errs++; $display("FAIL mid_word_count: got %0d want 1", word_count); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_back_to_back();
        test_stall();
        test_interval();
        test_resync_req();
        test_reset_midword();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/pcileech_com_tx64.md
# pcileech_com_tx64

Serializes 64-bit words from the FPGA core into a 32-bit communication-core stream, upper DWORD first, so the host reassembles them on a 64-bit boundary. With resync enabled it also inserts the 0x66665555/0x66665555 resync pair, the same sequence the COM RX packer uses to realign its 32->64 phase. It sits in the clk_com domain between the 64-bit TX buffering and the FT601/Ethernet 32-bit `din` interfaces.

## Interface
- RESYNC_INTERVAL, 16'd4096: 64-bit words between automatic resync pairs; 0 disables periodic insertion.
- clk  in  1  communication-core clock; everything is in this single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  64  word to send; [63:32] goes on the wire first.
- din_valid  in  1  `din` is valid.
- din_ready  out  1  block accepts `din` this cycle.
- dout  out  32  serialized DWORD.
- dout_valid  out  1  `dout` is valid.
- dout_ready  in  1  sink accepts `dout` this cycle.
- resync_req  in  1  one-cycle pulse requesting a resync pair.
- word_count  out  32  count of 64-bit words fully sent; wraps.
- sync_count  out  16  count of resync pairs fully sent; wraps.

## Operation
- Transfer rules:
  - Input transfer: `din_valid & din_ready`.
  - Output transfer: `dout_valid & dout_ready`.
- `hold[63:0]` captures `din` on an input transfer.
- FSM states: IDLE, HI, LO, SYNC1, SYNC2.
  - IDLE: `dout_valid=0`, `dout=0`. If resync is pending, go to SYNC1. Otherwise an input transfer goes to HI.
  - HI: `dout=hold[63:32]`. On output transfer, go to LO.
  - LO: `dout=hold[31:0]`. On output transfer, increment `word_count`, then:
    - resync pending: go to SYNC1;
    - otherwise input transfer this cycle: go to HI (back-to-back);
    - otherwise: go to IDLE.
  - SYNC1: `dout=32'h66665555`. On output transfer, go to SYNC2.
  - SYNC2: `dout=32'h66665555`. On output transfer, increment `sync_count` and go to IDLE.
- `dout_valid=1` in HI, LO, SYNC1 and SYNC2.
- `din_ready = ~pending & ((state==IDLE) | (state==LO & dout_ready))`. The path from `dout_ready` to `din_ready` is combinational and is intended.
- `pending` flag:
  - Set by `resync_req`, or by `interval_cnt` reaching RESYNC_INTERVAL (when RESYNC_INTERVAL != 0).
  - Cleared when entering SYNC1.
  - If a `resync_req` arrives while in SYNC1 or SYNC2, it sets `pending` again, so a second pair follows.
- `interval_cnt` (16 bits):
  - Increments on each LO output transfer.
  - Clears on entering SYNC1.
  - Saturates at RESYNC_INTERVAL.
- Resync pairs are only ever emitted on a 64-bit boundary; a word is never split by a resync pair.
- Once `dout_valid` is high, `dout` is held stable until the output transfer.

## Timing
- Reset values:
  - state=IDLE, `hold=0`, `dout=0`, `dout_valid=0`, `word_count=0`, `sync_count=0`, `interval_cnt=0`.
  - `pending` resets to 1 when the macro is defined, otherwise 0.
  - `din_ready`: 1 out of reset, except 0 while the reset-time `pending` is set.
- Latency: a word accepted in cycle N gives its upper DWORD valid in N+1 and its lower DWORD in N+2, provided `dout_ready` is held high.
- Throughput: 1 DWORD per clock when `dout_ready` is continuously high; no bubble between consecutive words.
- `dout_ready` low: state, `dout` and `hold` are frozen.
- Reset asserted mid-word: the remaining DWORDs are discarded; after release the block starts in IDLE. With the macro defined, the first output is a resync pair.
- `resync_req` in the same cycle as an input transfer in IDLE: IDLE has priority for resync, so `din_ready=0` that cycle only if `pending` was already set. The new request applies at the next boundary.

## Configuration
- Macro: COM_TX_RESYNC_EN.
- Defined:
  - resync insertion, `resync_req`, RESYNC_INTERVAL and `sync_count` are active;
  - `pending` resets to 1.
- Undefined:
  - SYNC1/SYNC2 are unreachable, `pending` is tied to 0 and `resync_req` is ignored;
  - `sync_count` is constant 0 and RESYNC_INTERVAL has no effect;
  - output is pure 64->32 serialization.

## Test plan
- Macro on, release reset, `dout_ready=1`, no input -> `dout` = 66665555, 66665555 in the first two valid cycles; then `dout_valid=0`; `sync_count=1`.
- Push 64'h11111111_22222222 then 64'h33333333_44444444 back-to-back, `dout_ready=1` -> `dout` = 11111111, 22222222, 33333333, 44444444 on consecutive cycles; `word_count=2`.
- Toggle `dout_ready` 1/0 every cycle while streaming 8 words -> no DWORD lost or duplicated; `dout` stable during each stall.
- RESYNC_INTERVAL=4, stream 10 words -> a resync pair after words 4 and 8 only; never between the HI and LO halves of a word.
- Pulse `resync_req` while the upper DWORD of a word is on `dout` -> that word's lower DWORD is sent, then 66665555 x2, then the next word.
- Assert `rst_n=0` right after the upper DWORD transfers -> all outputs return to their reset values asynchronously; the lower DWORD is never emitted.
